// File: rtl/riscv_next_pkg.sv
// Shared types and constants for the next-instruction pre-decoder.
// Holds the decode result struct, control-flow opcodes, the halt word and the link registers.
package riscv_next_pkg;

   localparam logic [6:0]  OP_JAL    = 7'b1101111;
   localparam logic [6:0]  OP_JALR   = 7'b1100111;
   localparam logic [6:0]  OP_BRANCH = 7'b1100011;

   // EBREAK is used as the simulation halt marker.
   localparam logic [31:0] HALT      = 32'h0010_0073;

   localparam logic [4:0]  LINK_RA   = 5'd1;
   localparam logic [4:0]  LINK_T0   = 5'd5;

   typedef struct packed {
      logic        valid;
      logic        is_jal;
      logic        is_jalr;
      logic        is_branch;
      logic        is_call;
      logic        is_return;
      logic        is_halt;
      logic        target_valid;
      logic [2:0]  funct3;
      logic [4:0]  rs1;
      logic [4:0]  rd;
      logic [63:0] imm;
   } next_instr_signals_t;

   function automatic logic is_link(input logic [4:0] reg_idx);
      return (reg_idx == LINK_RA) || (reg_idx == LINK_T0);
   endfunction

endpackage

// File: rtl/riscv_next_instr_decode_comb.sv
// Combinational control-flow decode of one RV32/RV64 instruction word.
// Produces the classification struct and the PC-relative target; a flush forces all zeros.
module riscv_next_instr_decode_comb
   import riscv_next_pkg::*;
#(
   parameter int INSTR_WIDTH = 32,
   parameter int ADDR_WIDTH  = 64
) (
   input  logic                   i_flush,
   input  logic [ADDR_WIDTH-1:0]  i_pc,
   input  logic [INSTR_WIDTH-1:0] i_instr,
   output next_instr_signals_t    o_signals,
   output logic [ADDR_WIDTH-1:0]  o_target
);

   logic [6:0]  w_opcode;
   logic [2:0]  w_funct3;
   logic        w_full;
   logic        w_jal;
   logic        w_jalr;
   logic        w_branch;
   logic [63:0] w_imm;

   assign w_opcode = i_instr[6:0];
   assign w_funct3 = i_instr[14:12];
   // Compressed or garbage encodings never classify as control flow.
   assign w_full   = (i_instr[1:0] == 2'b11);
   assign w_jal    = w_full && (w_opcode == OP_JAL);
   assign w_jalr   = w_full && (w_opcode == OP_JALR) && (w_funct3 == 3'b000);
   assign w_branch = w_full && (w_opcode == OP_BRANCH)
                     && (w_funct3 != 3'b010) && (w_funct3 != 3'b011);

   always_comb begin
      // NOTE: default first so no path through the block leaves w_imm unassigned (no latch).
      w_imm = '0;
      if (w_jal) begin
         w_imm = {{44{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
      end else if (w_jalr) begin
         w_imm = {{52{i_instr[31]}}, i_instr[31:20]};
      end else if (w_branch) begin
         w_imm = {{52{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
      end
   end

   always_comb begin
      o_signals              = '0;
      o_target               = '0;
      if (!i_flush) begin
         o_signals.valid        = 1'b1;
         o_signals.is_jal       = w_jal;
         o_signals.is_jalr      = w_jalr;
         o_signals.is_branch    = w_branch;
         o_signals.is_call      = (w_jal || w_jalr) && is_link(i_instr[11:7]);
         o_signals.is_return    = w_jalr && is_link(i_instr[19:15]) && !is_link(i_instr[11:7]);
         o_signals.is_halt      = (i_instr[31:0] == HALT);
         // JALR depends on rs1, which is not known at this stage.
         o_signals.target_valid = w_jal || w_branch;
         o_signals.funct3       = w_funct3;
         o_signals.rs1          = i_instr[19:15];
         o_signals.rd           = i_instr[11:7];
         o_signals.imm          = w_imm;
         o_target               = i_pc + w_imm[ADDR_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/riscv_next_instr_predecoder.sv
// Registered next-PC pre-decoder: one-cycle decode stage with stall and flush.
// Flush loads zeros and wins over stall; reset clears asynchronously.
module riscv_next_instr_predecoder
   import riscv_next_pkg::*;
#(
   parameter int INSTR_WIDTH = 32,
   parameter int ADDR_WIDTH  = 64
) (
   input  logic                   aclk,
   input  logic                   areset,
   input  logic                   i_stall,
   input  logic                   i_flush,
   input  logic [ADDR_WIDTH-1:0]  i_pc,
   input  logic [INSTR_WIDTH-1:0] i_instr,
   output next_instr_signals_t    o_signals,
   output logic [ADDR_WIDTH-1:0]  o_target
);

   next_instr_signals_t   w_signals;
   logic [ADDR_WIDTH-1:0] w_target;
   next_instr_signals_t   r_signals;
   logic [ADDR_WIDTH-1:0] r_target;

   riscv_next_instr_decode_comb #(
      .INSTR_WIDTH (INSTR_WIDTH),
      .ADDR_WIDTH  (ADDR_WIDTH)
   ) u_decode (
      .i_flush   (i_flush),
      .i_pc      (i_pc),
      .i_instr   (i_instr),
      .o_signals (w_signals),
      .o_target  (w_target)
   );

   always_ff @(posedge aclk or posedge areset) begin
      // NOTE: non-blocking assignments for registered state so all flops sample together.
      if (areset) begin
         r_signals <= '0;
         r_target  <= '0;
      end else if (i_flush || !i_stall) begin
         r_signals <= w_signals;
         r_target  <= w_target;
      end
   end

   assign o_signals = r_signals;
   assign o_target  = r_target;

endmodule

// File: tb/tb_riscv_next_instr_predecoder.sv
// Directed scoreboard bench for riscv_next_instr_predecoder.
// Expected results are queued when stimulus is driven and popped one cycle later.
module tb_riscv_next_instr_predecoder;
   import riscv_next_pkg::*;

   typedef struct packed {
      next_instr_signals_t sig;
      logic [63:0]         tgt;
   } exp_t;

   logic                aclk = 1'b0;
   logic                areset;
   logic                i_stall;
   logic                i_flush;
   logic [63:0]         i_pc;
   logic [31:0]         i_instr;
   next_instr_signals_t o_signals;
   logic [63:0]         o_target;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   riscv_next_instr_predecoder #(
      .INSTR_WIDTH (32),
      .ADDR_WIDTH  (64)
   ) dut (
      .aclk      (aclk),
      .areset    (areset),
      .i_stall   (i_stall),
      .i_flush   (i_flush),
      .i_pc      (i_pc),
      .i_instr   (i_instr),
      .o_signals (o_signals),
      .o_target  (o_target)
   );

   always #5 aclk = ~aclk;

   function automatic exp_t mk(input logic jal, input logic jalr, input logic br,
                               input logic call, input logic ret, input logic halt,
                               input logic tv, input logic [2:0] f3, input logic [4:0] rs1,
                               input logic [4:0] rd, input logic [63:0] imm,
                               input logic [63:0] tgt);
      exp_t e;
      e.sig.valid        = 1'b1;
      e.sig.is_jal       = jal;
      e.sig.is_jalr      = jalr;
      e.sig.is_branch    = br;
      e.sig.is_call      = call;
      e.sig.is_return    = ret;
      e.sig.is_halt      = halt;
      e.sig.target_valid = tv;
      e.sig.funct3       = f3;
      e.sig.rs1          = rs1;
      e.sig.rd           = rd;
      e.sig.imm          = imm;
      e.tgt              = tgt;
      return e;
   endfunction

   task automatic chk(input string tag, input exp_t e);
      checks++;
      assert (o_signals === e.sig) else begin
         errors++;
         $error("FAIL %s signals: got %h expected %h", tag, o_signals, e.sig);
      end
      checks++;
      assert (o_target === e.tgt) else begin
         errors++;
         $error("FAIL %s target: got %h expected %h", tag, o_target, e.tgt);
      end
   endtask

   task automatic step(input string tag, input logic [63:0] pc, input logic [31:0] instr,
                       input logic st, input logic fl, input exp_t e);
      exp_t got_exp;
      @(negedge aclk);
      i_pc    = pc;
      i_instr = instr;
      i_stall = st;
      i_flush = fl;
      sb_q.push_back(e);
      @(posedge aclk);
      #1;
      got_exp = sb_q.pop_front();
      chk(tag, got_exp);
   endtask

   exp_t e_zero, e_addi, e_jal, e_jalr_ret, e_br_back, e_br_wrap, e_halt;
   exp_t e_br_010, e_jalr_001, e_jalr_call, e_cmp;

   initial begin
      e_zero      = '0;
      e_addi      = mk(0,0,0, 0,0,0, 0, 3'd0, 5'd0, 5'd0,  64'd0, 64'h40);
      e_jal       = mk(1,0,0, 1,0,0, 1, 3'd0, 5'd0, 5'd1,  64'd8, 64'h108);
      e_jalr_ret  = mk(0,1,0, 0,1,0, 0, 3'd0, 5'd1, 5'd0,  64'd0, 64'h300);
      e_br_back   = mk(0,0,1, 0,0,0, 1, 3'd0, 5'd0, 5'd29, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1FC);
      e_br_wrap   = mk(0,0,1, 0,0,0, 1, 3'd0, 5'd0, 5'd29, 64'hFFFF_FFFF_FFFF_FFFC,
                       64'hFFFF_FFFF_FFFF_FFFC);
      e_halt      = mk(0,0,0, 0,0,1, 0, 3'd0, 5'd0, 5'd0,  64'd0, 64'h500);
      e_br_010    = mk(0,0,0, 0,0,0, 0, 3'd2, 5'd0, 5'd0,  64'd0, 64'h600);
      e_jalr_001  = mk(0,0,0, 0,0,0, 0, 3'd1, 5'd1, 5'd1,  64'd0, 64'h700);
      e_jalr_call = mk(0,1,0, 1,0,0, 0, 3'd0, 5'd5, 5'd1,  64'd16, 64'h1010);
      e_cmp       = mk(0,0,0, 0,0,0, 0, 3'd0, 5'd0, 5'd31, 64'd0, 64'h800);

      areset  = 1'b1;
      i_stall = 1'b0;
      i_flush = 1'b0;
      i_pc    = 64'h100;
      i_instr = 32'h008000EF;

      // Outputs stay zero while reset is held, regardless of inputs.
      for (int k = 0; k < 3; k++) begin
         @(negedge aclk);
         i_pc    = 64'h100 + 64'(k);
         i_instr = (k == 1) ? 32'hFE000EE3 : 32'h008000EF;
         @(posedge aclk);
         #1;
         chk("reset_hold", e_zero);
      end

      @(negedge aclk);
      areset = 1'b0;
      step("addi_after_reset", 64'h40,   32'h0000_0013, 0, 0, e_addi);
      step("jal_call",         64'h100,  32'h0080_00EF, 0, 0, e_jal);
      step("jalr_return",      64'h300,  32'h0000_8067, 0, 0, e_jalr_ret);
      step("branch_back",      64'h200,  32'hFE00_0EE3, 0, 0, e_br_back);
      step("branch_wrap",      64'h0,    32'hFE00_0EE3, 0, 0, e_br_wrap);
      step("halt",             64'h500,  32'h0010_0073, 0, 0, e_halt);
      step("branch_f3_010",    64'h600,  32'h0000_2063, 0, 0, e_br_010);
      step("jalr_f3_001",      64'h700,  32'h0000_90E7, 0, 0, e_jalr_001);
      step("jalr_call",        64'h1000, 32'h0102_80E7, 0, 0, e_jalr_call);
      step("compressed",       64'h800,  32'h0000_0F81, 0, 0, e_cmp);

      step("jal_reload",       64'h100,  32'h0080_00EF, 0, 0, e_jal);
      step("stall_hold_1",     64'h500,  32'h0010_0073, 1, 0, e_jal);
      step("stall_hold_2",     64'h200,  32'hFE00_0EE3, 1, 0, e_jal);
      step("flush_and_stall",  64'h200,  32'hFE00_0EE3, 1, 1, e_zero);
      step("addi_after_flush", 64'h40,   32'h0000_0013, 0, 0, e_addi);
      step("flush_only",       64'h100,  32'h0080_00EF, 0, 1, e_zero);
      step("jal_before_stall", 64'h100,  32'h0080_00EF, 0, 0, e_jal);

      // Reset in the middle of a stall clears immediately, before any edge.
      @(negedge aclk);
      i_stall = 1'b1;
      #2;
      areset = 1'b1;
      #1;
      chk("reset_mid_stall_async", e_zero);
      @(posedge aclk);
      #1;
      chk("reset_mid_stall_held", e_zero);
      @(negedge aclk);
      areset = 1'b0;
      step("addi_after_reset2", 64'h40,  32'h0000_0013, 0, 0, e_addi);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/riscv_next_instr_predecoder.md
# riscv_next_instr_predecoder

Registered pre-decoder for the next-PC / jump-prediction path of the pipelined RV64 core. It takes the fetched instruction word and its PC and classifies it as JAL, JALR, conditional branch, call, return or halt. It extracts the immediate and computes the PC-relative target. Its output struct feeds the jump predictors and the verification bench's per-instruction decode.

## Interface
Parameters:
- INSTR_WIDTH, 32, instruction word width; only 32 is supported.
- ADDR_WIDTH, 64, PC/target width.

Ports:
- aclk  in  1  single clock; all state updates on the rising edge.
- areset  in  1  reset, asynchronous, active-high.
- i_stall  in  1  hold the output registers.
- i_flush  in  1  squash the current slot.
- i_pc  in  ADDR_WIDTH  PC of i_instr.
- i_instr  in  INSTR_WIDTH  fetched instruction.
- o_signals  out  next_instr_signals_t  registered decode result.
- o_target  out  ADDR_WIDTH  registered i_pc + imm, wrapping modulo 2^ADDR_WIDTH.

## Operation
- next_instr_signals_t fields:
  - valid
  - is_jal, is_jalr, is_branch
  - is_call, is_return, is_halt
  - target_valid
  - funct3[2:0], rs1[4:0], rd[4:0]
  - imm[63:0], sign-extended
- Any i_instr[1:0] != 2'b11 (compressed or garbage): valid=1, all classification flags 0, imm=0.
- JAL (opcode 1101111):
  - is_jal=1.
  - imm = sext({i[31],i[19:12],i[20],i[30:21],1'b0}).
  - target_valid=1.
- JALR (opcode 1100111, funct3=000):
  - is_jalr=1.
  - imm = sext(i[31:20]).
  - target_valid=0, because rs1 is unknown here.
  - JALR with any other funct3: flags 0.
- BRANCH (opcode 1100011, funct3 in {000,001,100,101,110,111}):
  - is_branch=1.
  - imm = sext({i[31],i[7],i[30:25],i[11:8],1'b0}).
  - target_valid=1.
  - funct3 010/011: flags 0.
- Call: (is_jal or is_jalr) and rd in {x1,x5}.
- Return: is_jalr, rs1 in {x1,x5}, and rd not in {x1,x5}.
- is_halt: i_instr == HALT, independent of the other flags.
- rs1, rd, funct3 are always copied raw from the instruction fields.
- Non-control instructions: valid=1, all flags 0, imm=0, o_target = i_pc.

## Timing
- Latency: exactly 1 cycle from i_instr/i_pc to o_signals/o_target.
- Reset: o_signals = all zeros (valid=0) and o_target = 0, asynchronously, held while areset=1.
- First edge after reset release loads the decode result normally.
- Flush: i_flush=1 at an edge loads all zeros (valid=0, target 0).
- Stall: i_stall=1 without flush keeps the registers unchanged.
- Simultaneous flush and stall: flush wins.
- Reset asserted mid-stall clears immediately; there is no retained state.

## Structure
- Shared package riscv_next_pkg holds:
  - next_instr_signals_t (packed struct)
  - opcode localparams OP_JAL, OP_JALR, OP_BRANCH
  - HALT = 32'h0010_0073 (EBREAK)
  - link-register constants 5'd1 and 5'd5
- Sub-module riscv_next_instr_decode_comb: purely combinational decode of i_instr, i_pc and i_flush into the struct plus target. The top wraps it with the register stage.

## Test plan
- Reset: hold areset=1, toggle inputs → o_signals all zero and o_target=0 throughout. Deassert with i_instr=0x00000013 (addi) → next cycle valid=1, all flags 0.
- JAL call: i_pc=0x100, i_instr=0x008000EF (jal x1,8) → next cycle is_jal=1, is_call=1, rd=1, imm=8, o_target=0x108, target_valid=1.
- JALR return: i_instr=0x00008067 (jalr x0,0(x1)) → is_jalr=1, is_return=1, is_call=0, target_valid=0, imm=0.
- Branch backward: i_pc=0x200, i_instr=0xFE000EE3 (beq x0,x0,-4) → is_branch=1, imm=0xFFFF_FFFF_FFFF_FFFC, o_target=0x1FC. Same with i_pc=0 → o_target=0xFFFF_FFFF_FFFF_FFFC (wrap).
- Halt and invalid funct3: i_instr=0x00100073 → is_halt=1, other flags 0. A branch opcode with funct3=010 → is_branch=0.
- Flush/stall: load the JAL case, then hold i_stall=1 with new i_instr → output unchanged. Assert i_flush and i_stall together → valid=0 next cycle.
